// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the machine-mode trap controller.
package trap_ctrl_pkg;

  localparam int unsigned IRQ_MSI = 3;
  localparam int unsigned IRQ_MTI = 7;
  localparam int unsigned IRQ_MEI = 11;

  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    TS_IDLE,
    TS_REQ,
    TS_REDIR
  } trap_state_t;

endpackage

// File: rtl/trap_ctrl_mtimer.sv
// Machine timer: prescaled mtime counter, mtimecmp register and MTIP compare.
module trap_ctrl_mtimer
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mtime_we,
  input  logic            mtimecmp_we,
  input  logic [XLEN-1:0] timer_wdata,
  output logic [XLEN-1:0] mtime,
  output logic [XLEN-1:0] mtimecmp,
  output logic            mtip
);

  localparam logic [7:0] PrescMax = 8'(TICK_DIV - 1);

  logic [7:0] presc_q;
  logic       tick;

  assign tick = (presc_q == PrescMax);

  // Prescaler counts 0..TICK_DIV-1 and wraps on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= 8'd0;
    end else if (tick) begin
      presc_q <= 8'd0;
    end else begin
      presc_q <= presc_q + 8'd1;
    end
  end

  // mtime: software write has priority over the tick increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
    end else begin
      if (mtime_we) begin
        mtime <= timer_wdata;
      end else if (tick) begin
        mtime <= mtime + XLEN'(1);
      end
      if (mtimecmp_we) begin
        mtimecmp <= timer_wdata;
      end
    end
  end

  // Compare on register values, so MTIP reflects a write one cycle later.
  assign mtip = (mtime >= mtimecmp);

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode interrupt sources, arbitration and trap-entry sequencer.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic            ext_irq_in,
  input  logic            msip_set,
  input  logic            msip_clr,
  input  logic            mtime_we,
  input  logic            mtimecmp_we,
  input  logic [XLEN-1:0] timer_wdata,
  output logic [XLEN-1:0] mtime,
  output logic [XLEN-1:0] mtimecmp,
  output logic [XLEN-1:0] mip_value,
  output logic            irq_req,
  output logic [XLEN-1:0] irq_cause,
  input  logic            irq_ack,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CodeW = $clog2(XLEN);

  logic            mtip;
  logic            msip_q;
  logic            ext_meta_q, ext_sync_q;
  logic            global_en;
  logic [XLEN-1:0] pend;
  logic [CodeW-1:0] best_code;
  logic            latched_live;
  logic [XLEN-1:0] vec_base, handler_pc;

  trap_state_t     state_q, state_d;
  logic            req_d, rv_d;
  logic [XLEN-1:0] cause_d, rpc_d;

  trap_ctrl_mtimer #(
    .XLEN    (XLEN),
    .TICK_DIV(TICK_DIV)
  ) u_mtimer (
    .clk        (clk),
    .rst        (rst),
    .mtime_we   (mtime_we),
    .mtimecmp_we(mtimecmp_we),
    .timer_wdata(timer_wdata),
    .mtime      (mtime),
    .mtimecmp   (mtimecmp),
    .mtip       (mtip)
  );

  // Software interrupt bit (set wins) and two-flop external IRQ synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip_q     <= 1'b0;
      ext_meta_q <= 1'b0;
      ext_sync_q <= 1'b0;
    end else begin
      if (msip_set) begin
        msip_q <= 1'b1;
      end else if (msip_clr) begin
        msip_q <= 1'b0;
      end
      ext_meta_q <= ext_irq_in;
      ext_sync_q <= ext_meta_q;
    end
  end

  // Live MIP image and fixed-priority arbitration MEI > MSI > MTI.
  always_comb begin
    mip_value          = '0;
    mip_value[IRQ_MEI] = ext_sync_q;
    mip_value[IRQ_MTI] = mtip;
    mip_value[IRQ_MSI] = msip_q;
    global_en          = (mode != 2'b11) || mstatus_mie;
    pend               = mip_value & mie;
    if (pend[IRQ_MEI]) begin
      best_code = CodeW'(IRQ_MEI);
    end else if (pend[IRQ_MSI]) begin
      best_code = CodeW'(IRQ_MSI);
    end else begin
      best_code = CodeW'(IRQ_MTI);
    end
    latched_live = global_en && pend[irq_cause[CodeW-1:0]];
  end

  // Handler address from mtvec; vectored mode adds 4*code to the base.
  always_comb begin
    vec_base = {mtvec[XLEN-1:2], 2'b00};
    if (mtvec[1:0] == MTVEC_MODE_VECTORED) begin
      handler_pc = vec_base + {irq_cause[XLEN-3:0], 2'b00};
    end else begin
      handler_pc = vec_base;
    end
  end

  // Trap sequencer next-state and registered outputs.
  always_comb begin
    state_d = state_q;
    req_d   = irq_req;
    rv_d    = 1'b0;
    cause_d = irq_cause;
    rpc_d   = redirect_pc;
    unique case (state_q)
      TS_IDLE: begin
        if (global_en && (pend != '0)) begin
          cause_d              = '0;
          cause_d[XLEN-1]      = 1'b1;
          cause_d[CodeW-1:0]   = best_code;
          req_d                = 1'b1;
          state_d              = TS_REQ;
        end
      end
      TS_REQ: begin
        // Ack beats a simultaneous drop of the latched source.
        if (irq_ack) begin
          req_d   = 1'b0;
          rv_d    = 1'b1;
          rpc_d   = handler_pc;
          state_d = TS_REDIR;
        end else if (!latched_live) begin
          req_d   = 1'b0;
          state_d = TS_IDLE;
        end
      end
      TS_REDIR: begin
        // One dead cycle lets the CSR file clear mstatus.mie before re-arm.
        req_d   = 1'b0;
        state_d = TS_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = TS_IDLE;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= TS_IDLE;
      irq_req        <= 1'b0;
      irq_cause      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      irq_req        <= req_d;
      irq_cause      <= cause_d;
      redirect_valid <= rv_d;
      redirect_pc    <= rpc_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the trap controller.
module tb_trap_ctrl;

  localparam int TD = 1;
  localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'b11;
  logic        mstatus_mie = 1'b0;
  logic [63:0] mie = '0;
  logic [63:0] mtvec = 64'h1000;
  logic        ext_irq_in = 1'b0;
  logic        msip_set = 1'b0;
  logic        msip_clr = 1'b0;
  logic        mtime_we = 1'b0;
  logic        mtimecmp_we = 1'b0;
  logic [63:0] timer_wdata = '0;
  logic        irq_ack = 1'b0;
  logic [63:0] mtime, mtimecmp, mip_value, irq_cause, redirect_pc;
  logic        irq_req, redirect_valid;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0 idle, 1 requesting, 2 redirecting.
  logic [63:0] m_mtime, m_cmp, m_cause, m_rpc;
  logic        m_msip, m_s1, m_s2, m_req, m_rv;
  int          m_phase, m_presc;

  trap_ctrl #(
    .XLEN    (64),
    .TICK_DIV(TD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .mstatus_mie   (mstatus_mie),
    .mie           (mie),
    .mtvec         (mtvec),
    .ext_irq_in    (ext_irq_in),
    .msip_set      (msip_set),
    .msip_clr      (msip_clr),
    .mtime_we      (mtime_we),
    .mtimecmp_we   (mtimecmp_we),
    .timer_wdata   (timer_wdata),
    .mtime         (mtime),
    .mtimecmp      (mtimecmp),
    .mip_value     (mip_value),
    .irq_req       (irq_req),
    .irq_cause     (irq_cause),
    .irq_ack       (irq_ack),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_mip();
    logic [63:0] v;
    v     = '0;
    v[11] = m_s2;
    v[7]  = (m_mtime >= m_cmp);
    v[3]  = m_msip;
    return v;
  endfunction

  task automatic model_reset();
    m_mtime = '0; m_cmp = '1; m_cause = '0; m_rpc = '0;
    m_msip = 0; m_s1 = 0; m_s2 = 0; m_req = 0; m_rv = 0;
    m_phase = 0; m_presc = 0;
  endtask

  task automatic check_all();
    check("mtime", mtime, m_mtime);
    check("mtimecmp", mtimecmp, m_cmp);
    check("mip_value", mip_value, model_mip());
    check("irq_req", 64'(irq_req), 64'(m_req));
    check("irq_cause", irq_cause, m_cause);
    check("redirect_valid", 64'(redirect_valid), 64'(m_rv));
    check("redirect_pc", redirect_pc, m_rpc);
  endtask

  // Advance one clock: predict from pre-edge inputs, then compare after the edge.
  task automatic step();
    logic [63:0] pend, n_mtime, n_cmp, n_cause, n_rpc, base, code;
    logic        glob, tick, n_msip, n_req, n_rv;
    int          n_phase, n_presc;
    pend    = model_mip() & mie;
    glob    = (mode != 2'b11) || mstatus_mie;
    n_mtime = m_mtime; n_cmp = m_cmp; n_cause = m_cause; n_rpc = m_rpc;
    n_msip  = m_msip; n_req = m_req; n_rv = 1'b0; n_phase = m_phase;
    tick    = (m_presc == TD - 1);
    n_presc = tick ? 0 : m_presc + 1;
    if (mtime_we) n_mtime = timer_wdata;
    else if (tick) n_mtime = m_mtime + 64'd1;
    if (mtimecmp_we) n_cmp = timer_wdata;
    if (msip_set) n_msip = 1'b1;
    else if (msip_clr) n_msip = 1'b0;
    case (m_phase)
      0: if (glob && pend != 0) begin
        n_req   = 1'b1;
        n_phase = 1;
        n_cause = MSB | (pend[11] ? 64'd11 : pend[3] ? 64'd3 : 64'd7);
      end
      1: if (irq_ack) begin
        n_req   = 1'b0;
        n_rv    = 1'b1;
        n_phase = 2;
        base    = mtvec & ~64'h3;
        code    = m_cause & ~MSB;
        n_rpc   = (mtvec[1:0] == 2'b01) ? base + code * 64'd4 : base;
      end else if (!(glob && pend[m_cause[5:0]])) begin
        n_req   = 1'b0;
        n_phase = 0;
      end
      default: begin
        n_req   = 1'b0;
        n_phase = 0;
      end
    endcase
    @(posedge clk);
    #1;
    m_s2 = m_s1; m_s1 = ext_irq_in;
    m_mtime = n_mtime; m_cmp = n_cmp; m_cause = n_cause; m_rpc = n_rpc;
    m_msip = n_msip; m_req = n_req; m_rv = n_rv; m_phase = n_phase; m_presc = n_presc;
    msip_set = 0; msip_clr = 0; mtime_we = 0; mtimecmp_we = 0; irq_ack = 0;
    check_all();
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!irq_req && n < 40) begin
      step();
      n++;
    end
    check(tag, 64'(irq_req), 64'd1);
  endtask

  // Assert reset between edges; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_req"}, 64'(irq_req), 64'd0);
    check({tag, "_rv"}, 64'(redirect_valid), 64'd0);
    check({tag, "_mtime"}, mtime, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    #1;
    do_reset("reset");
    check("reset_cmp", mtimecmp, '1);
    check("reset_cause", irq_cause, 64'd0);

    // Timer interrupt, held request, direct-mode redirect.
    mode = 2'b11; mstatus_mie = 1; mie = 64'h80; mtvec = 64'h1000;
    timer_wdata = 64'd10; mtimecmp_we = 1; step();
    timer_wdata = 64'd0; mtime_we = 1; step();
    wait_req("mti_req");
    check("mti_mtime", mtime, 64'd11);
    check("mti_cause", irq_cause, 64'h8000_0000_0000_0007);
    repeat (3) step();
    check("mti_hold", 64'(irq_req), 64'd1);
    irq_ack = 1; mie = 0; step();
    check("mti_rv", 64'(redirect_valid), 64'd1);
    check("mti_pc", redirect_pc, 64'h1000);
    step();
    check("mti_rv_once", 64'(redirect_valid), 64'd0);

    // Vectored external interrupt.
    mtvec = 64'h8000_0101; mie = 64'h800; ext_irq_in = 1;
    wait_req("mei_req");
    check("mei_cause", irq_cause, 64'h8000_0000_0000_000B);
    irq_ack = 1; mie = 0; ext_irq_in = 0; step();
    check("mei_vec_pc", redirect_pc, 64'h8000_012C);
    step();

    // Priority with all three pending.
    mtvec = 64'h2000; msip_set = 1; ext_irq_in = 1;
    repeat (3) step();
    mie = 64'h888;
    wait_req("prio_req0");
    check("prio_mei", irq_cause, MSB | 64'd11);
    irq_ack = 1; mie = 0; ext_irq_in = 0; step();
    repeat (3) step();
    mie = 64'h888;
    wait_req("prio_req1");
    check("prio_msi", irq_cause, MSB | 64'd3);
    irq_ack = 1; msip_clr = 1; mie = 0; step();
    step();
    mie = 64'h888;
    wait_req("prio_req2");
    check("prio_mti", irq_cause, MSB | 64'd7);
    irq_ack = 1; mie = 0; step();
    step();

    // Withdraw on global disable; ack beats simultaneous drop.
    mie = 64'h80;
    wait_req("wd_req");
    mstatus_mie = 0; step();
    check("wd_drop", 64'(irq_req), 64'd0);
    repeat (2) step();
    check("wd_no_rv", 64'(redirect_valid), 64'd0);
    mstatus_mie = 1;
    wait_req("wd_req2");
    irq_ack = 1; mstatus_mie = 0; step();
    check("wd_ack_rv", 64'(redirect_valid), 64'd1);
    step();

    // Gating by privilege mode, and set-beats-clear for MSIP.
    mie = 64'h8; mode = 2'b00; mstatus_mie = 0; msip_set = 1; step();
    wait_req("gate_user");
    check("gate_cause", irq_cause, MSB | 64'd3);
    irq_ack = 1; step();
    step();
    mode = 2'b11;
    repeat (4) step();
    check("gate_m_noreq", 64'(irq_req), 64'd0);
    msip_clr = 1; step();
    msip_set = 1; msip_clr = 1; step();
    check("msip_set_wins", mip_value & 64'h8, 64'h8);

    // mtime wrap and synchroniser latency.
    mie = 0;
    timer_wdata = '1; mtime_we = 1; step();
    check("wrap_max", mtime, '1);
    step();
    check("wrap_zero", mtime, 64'd0);
    ext_irq_in = 1; step();
    ext_irq_in = 0;
    check("sync_k", mip_value & 64'h800, 64'h0);
    step();
    check("sync_k1", mip_value & 64'h800, 64'h800);
    step();
    check("sync_k2", mip_value & 64'h800, 64'h0);

    // Reset mid-REQ and mid-REDIR.
    mstatus_mie = 1; mie = 64'h8;
    wait_req("rst_req");
    do_reset("rst_in_req");
    mie = 64'h8; msip_set = 1; step();
    wait_req("rst_req2");
    irq_ack = 1; step();
    check("rst_redir_rv", 64'(redirect_valid), 64'd1);
    do_reset("rst_in_redir");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      mode        = 2'($urandom_range(0, 3));
      mstatus_mie = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) mie = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) mtvec = {$urandom, $urandom & 32'hFFFF_FFFD};
      if ($urandom_range(0, 5) == 0) ext_irq_in = ~ext_irq_in;
      msip_set = ($urandom_range(0, 7) == 0);
      msip_clr = ($urandom_range(0, 7) == 0);
      irq_ack  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) begin
        mtimecmp_we = 1;
        timer_wdata = m_mtime + 64'($urandom_range(0, 20));
      end else if ($urandom_range(0, 31) == 0) begin
        mtime_we    = 1;
        timer_wdata = m_cmp - 64'($urandom_range(0, 8));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
